// File: rtl/clock_meter_pkg.sv
// Shared types and constants for the divided-clock ratio meter.
// Imported by the meter top and its helper sub-modules.
package clock_meter_pkg;

  typedef enum logic {
    WAIT_EDGE = 1'b0,
    MEASURE   = 1'b1
  } meter_state_e;

  localparam int DEFAULT_CNT_W = 16;

  // All-ones counter value at which a measurement is abandoned.
  localparam logic [DEFAULT_CNT_W-1:0] DEFAULT_CNT_SAT = {DEFAULT_CNT_W{1'b1}};

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous level, with one extra delay flop
// so that single-cycle rise and fall strobes can be derived in the clk_in domain.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_dly_d;
  logic                   s_dly_q;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], d};
    s_dly_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      s_dly_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      s_dly_q <= s_dly_d;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_dly_q;
  assign fall = ~s & s_dly_q;

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures rise-to-rise period and high time of an asynchronous divided clock
// in clk_in cycles, tracking lock on repeated periods and a sticky timeout.
module clock_ratio_meter
  import clock_meter_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             div_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam int               MATCH_W   = $clog2(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1'b1);

  logic rise_s;
  logic fall_s;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (div_in),
    .s      (),
    .rise   (rise_s),
    .fall   (fall_s)
  );

  meter_state_e   state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] hi_cap_d, hi_cap_q;
  logic [CNT_W-1:0] period_d, period_q;
  logic [CNT_W-1:0] high_time_d, high_time_q;
  logic [MATCH_W-1:0] match_d, match_q;
  logic             have_prev_d, have_prev_q;
  logic             valid_d, valid_q;
  logic             locked_d, locked_q;
  logic             timeout_d, timeout_q;
  logic [MATCH_W-1:0] match_next;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_cap_d    = hi_cap_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    match_d     = match_q;
    have_prev_d = have_prev_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    match_next  = '0;

    if (have_prev_q && (cnt_q == period_q)) begin
      match_next = (match_q == MATCH_MAX) ? match_q : (match_q + MATCH_ONE);
    end

    if (!en) begin
      state_d     = WAIT_EDGE;
      cnt_d       = '0;
      match_d     = '0;
      have_prev_d = 1'b0;
      locked_d    = 1'b0;
    end else begin
      case (state_q)
        WAIT_EDGE: begin
          cnt_d = '0;
          if (rise_s) begin
            cnt_d   = CNT_ONE;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          cnt_d = cnt_q + CNT_ONE;
          if (fall_s) begin
            hi_cap_d = cnt_q;
          end
          // A rise on the saturating cycle still completes the measurement.
          if (rise_s) begin
            period_d    = cnt_q;
            high_time_d = hi_cap_q;
            valid_d     = 1'b1;
            cnt_d       = CNT_ONE;
            timeout_d   = 1'b0;
            have_prev_d = 1'b1;
            match_d     = match_next;
            locked_d    = (match_next >= MATCH_MAX);
          end else if (cnt_q == CNT_SAT) begin
            state_d     = WAIT_EDGE;
            cnt_d       = '0;
            timeout_d   = 1'b1;
            locked_d    = 1'b0;
            match_d     = '0;
            have_prev_d = 1'b0;
          end
        end
        default: begin
          state_d = WAIT_EDGE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_EDGE;
      cnt_q       <= '0;
      hi_cap_q    <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      match_q     <= '0;
      have_prev_q <= 1'b0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_cap_q    <= hi_cap_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      match_q     <= match_d;
      have_prev_q <= have_prev_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign timeout   = timeout_q;

endmodule
